// File: rtl/lcd_panel_driver_if.sv
`default_nettype none
// ============================================================================
// Module   : lcd_panel_driver_if
// Brief    : Framebuffer, request handshake and LCD pin bundle for the panel
//            driver. master = driver side, slave = framebuffer/panel side.
// Revision : 1.0 - initial release
// ============================================================================
interface lcd_panel_driver_if #(
    parameter int N  = 10,
    parameter int XW = 8,
    parameter int YW = 3
);
    logic          refresh;
    logic          auto_refresh;
    logic [7:0]    pixels;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          busy;
    logic          frame_done;
    logic [7:0]    data_pin;
    logic [N-1:0]  cs_pin;
    logic          rw_pin;
    logic          di_pin;
    logic          enable_pin;
    logic          reset_pin;

    modport master (
        input  refresh, auto_refresh, pixels,
        output x, y, busy, frame_done, data_pin, cs_pin, rw_pin, di_pin,
               enable_pin, reset_pin
    );

    modport slave (
        output refresh, auto_refresh, pixels,
        input  x, y, busy, frame_done, data_pin, cs_pin, rw_pin, di_pin,
               enable_pin, reset_pin
    );
endinterface
`default_nettype wire

// File: rtl/lcd_panel_driver.sv
`default_nettype none
// ============================================================================
// Module   : lcd_panel_driver
// Brief    : Init sequencer and framebuffer streamer for tiled column-driver
//            LCD panels with programmable bus timing and request queuing.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_panel_driver #(
    parameter int MODULES_PER_ROW  = 5,
    parameter int MODULE_ROWS      = 2,
    parameter int X_PER_MODULE     = 50,
    parameter int PAGES_PER_MODULE = 4,
    parameter int T_SETUP          = 8,
    parameter int T_PULSE          = 8,
    parameter int T_HOLD           = 8,
    parameter int RESET_HOLD       = 65536,
    parameter int FB_LAT           = 1
) (
    input  logic               clk,
    input  logic               reset,
    lcd_panel_driver_if.master bus
);
    localparam int C_N   = MODULES_PER_ROW * MODULE_ROWS;
    localparam int C_W   = MODULES_PER_ROW * X_PER_MODULE;
    localparam int C_YN  = MODULE_ROWS * PAGES_PER_MODULE;
    localparam int C_XW  = (C_W > 1) ? $clog2(C_W) : 1;
    localparam int C_YW  = (C_YN > 1) ? $clog2(C_YN) : 1;
    localparam int C_NW  = (C_N > 1) ? $clog2(C_N) : 1;
    localparam int C_CW  = (X_PER_MODULE > 1) ? $clog2(X_PER_MODULE) : 1;
    localparam int C_MW  = (MODULES_PER_ROW > 1) ? $clog2(MODULES_PER_ROW) : 1;
    localparam int C_RW  = (MODULE_ROWS > 1) ? $clog2(MODULE_ROWS) : 1;
    localparam int C_PW  = (PAGES_PER_MODULE > 1) ? $clog2(PAGES_PER_MODULE) : 1;
    localparam int C_BC  = T_SETUP + T_PULSE + T_HOLD;
    localparam int C_PHW = $clog2(C_BC);
    localparam int C_HW  = $clog2(RESET_HOLD + 1);

    localparam logic [C_PHW-1:0] C_PH_FALL = C_PHW'(T_SETUP - 1);
    localparam logic [C_PHW-1:0] C_PH_RISE = C_PHW'(T_SETUP + T_PULSE - 1);
    localparam logic [C_PHW-1:0] C_PH_PF   = C_PHW'(C_BC - 2 - FB_LAT);
    localparam logic [C_PHW-1:0] C_PH_END  = C_PHW'(C_BC - 1);
    localparam logic [C_HW-1:0]  C_HOLD    = C_HW'(RESET_HOLD);
    localparam logic [C_NW-1:0]  C_AC_END  = C_NW'(C_N - 1);
    localparam logic [C_CW-1:0]  C_COL_END = C_CW'(X_PER_MODULE - 1);
    localparam logic [C_MW-1:0]  C_MC_END  = C_MW'(MODULES_PER_ROW - 1);
    localparam logic [C_RW-1:0]  C_ROW_END = C_RW'(MODULE_ROWS - 1);
    localparam logic [C_PW-1:0]  C_PG_END  = C_PW'(PAGES_PER_MODULE - 1);
    localparam logic [C_N-1:0]   C_CS0     = C_N'(1);

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        CMD   = 2'd1,
        IDLE  = 2'd2,
        FRAME = 2'd3
    } state_t;

    state_t           r_state;
    logic [C_PHW-1:0] r_ph;
    logic [C_HW-1:0]  r_hold;
    logic [1:0]       r_cmd;
    logic [C_NW-1:0]  r_ac;
    logic [C_NW-1:0]  r_dchip;
    logic [C_CW-1:0]  r_col;
    logic [C_MW-1:0]  r_ccol;
    logic [C_RW-1:0]  r_row;
    logic [C_PW-1:0]  r_page;
    logic [C_XW-1:0]  r_x;
    logic [C_YW-1:0]  r_y;
    logic             r_in_data;
    logic             r_page_end;
    logic             r_last;
    logic             r_pending;
    logic [7:0]       r_data;
    logic [C_N-1:0]   r_cs;
    logic             r_di;
    logic             r_en;
    logic             r_rst_n;
    logic             r_busy;
    logic             r_done;

    logic             w_ph_end;
    logic [C_NW-1:0]  w_ac_next;
    logic [1:0]       w_page2;

    assign w_ph_end  = (r_ph == C_PH_END);
    assign w_ac_next = r_ac + C_NW'(1);
    assign w_page2   = 2'(r_page);

    function automatic logic [7:0] cmd_byte(input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = 8'h39;
            2'd1:    b = 8'h3B;
            default: b = 8'h3E;
        endcase
        return b;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= INIT;
            r_ph       <= '0;
            r_hold     <= '0;
            r_cmd      <= '0;
            r_ac       <= '0;
            r_dchip    <= '0;
            r_col      <= '0;
            r_ccol     <= '0;
            r_row      <= '0;
            r_page     <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_in_data  <= 1'b0;
            r_page_end <= 1'b0;
            r_last     <= 1'b0;
            r_pending  <= 1'b0;
            r_data     <= '0;
            r_cs       <= '0;
            r_di       <= 1'b0;
            r_en       <= 1'b1;
            r_rst_n    <= 1'b0;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (bus.refresh && r_state != IDLE)
                r_pending <= 1'b1;

            // Bus cycles run back-to-back in CMD and FRAME; the phase wraps at BC end.
            if (r_state == CMD || r_state == FRAME) begin
                r_ph <= w_ph_end ? '0 : r_ph + C_PHW'(1);
                if (r_ph == C_PH_FALL)
                    r_en <= 1'b0;
                else if (r_ph == C_PH_RISE)
                    r_en <= 1'b1;
            end

            case (r_state)
                INIT: begin
                    r_rst_n <= 1'b1;
                    if (r_hold == C_HOLD) begin
                        r_state <= CMD;
                        r_ph    <= '0;
                        r_en    <= 1'b1;
                        r_cs    <= C_CS0;
                        r_di    <= 1'b0;
                        r_data  <= cmd_byte(2'd0);
                    end else begin
                        r_hold <= r_hold + C_HW'(1);
                    end
                end

                CMD: begin
                    if (w_ph_end) begin
                        if (r_ac == C_AC_END) begin
                            r_ac <= '0;
                            if (r_cmd == 2'd2) begin
                                r_state <= IDLE;
                                r_cmd   <= '0;
                                r_cs    <= '0;
                                r_busy  <= 1'b0;
                            end else begin
                                r_cmd  <= r_cmd + 2'd1;
                                r_cs   <= C_CS0;
                                r_data <= cmd_byte(r_cmd + 2'd1);
                            end
                        end else begin
                            r_ac <= w_ac_next;
                            r_cs <= C_CS0 << w_ac_next;
                        end
                    end
                end

                IDLE: begin
                    if (bus.refresh || r_pending || bus.auto_refresh) begin
                        r_pending <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= FRAME;
                        r_in_data <= 1'b0;
                        r_ac      <= '0;
                        r_ph      <= '0;
                        r_en      <= 1'b1;
                        r_cs      <= C_CS0;
                        r_di      <= 1'b0;
                        r_data    <= {w_page2, 6'b0};
                    end
                end

                FRAME: begin
                    // Step x/y to the next data address FB_LAT+1 clocks before its BC starts.
                    if (r_in_data && r_ph == C_PH_PF) begin
                        if (r_col == C_COL_END) begin
                            r_col <= '0;
                            if (r_ccol == C_MC_END) begin
                                r_ccol <= '0;
                                r_x    <= '0;
                                if (r_row == C_ROW_END) begin
                                    r_row      <= '0;
                                    r_dchip    <= '0;
                                    r_page_end <= 1'b1;
                                    if (r_page == C_PG_END) begin
                                        r_page <= '0;
                                        r_y    <= '0;
                                        r_last <= 1'b1;
                                    end else begin
                                        r_page <= r_page + C_PW'(1);
                                        r_y    <= C_YW'(r_page) + C_YW'(1);
                                    end
                                end else begin
                                    r_row   <= r_row + C_RW'(1);
                                    r_dchip <= r_dchip + C_NW'(1);
                                    r_y     <= r_y + C_YW'(PAGES_PER_MODULE);
                                end
                            end else begin
                                r_ccol  <= r_ccol + C_MW'(1);
                                r_dchip <= r_dchip + C_NW'(1);
                                r_x     <= r_x + C_XW'(1);
                            end
                        end else begin
                            r_col <= r_col + C_CW'(1);
                            r_x   <= r_x + C_XW'(1);
                        end
                    end

                    if (w_ph_end) begin
                        if (!r_in_data) begin
                            if (r_ac == C_AC_END) begin
                                r_ac      <= '0;
                                r_in_data <= 1'b1;
                                r_cs      <= C_CS0 << r_dchip;
                                r_di      <= 1'b1;
                                r_data    <= bus.pixels;
                            end else begin
                                r_ac <= w_ac_next;
                                r_cs <= C_CS0 << w_ac_next;
                            end
                        end else if (r_last) begin
                            r_last     <= 1'b0;
                            r_page_end <= 1'b0;
                            r_in_data  <= 1'b0;
                            r_done     <= 1'b1;
                            r_busy     <= 1'b0;
                            r_cs       <= '0;
                            r_state    <= IDLE;
                        end else if (r_page_end) begin
                            r_page_end <= 1'b0;
                            r_in_data  <= 1'b0;
                            r_cs       <= C_CS0;
                            r_di       <= 1'b0;
                            r_data     <= {w_page2, 6'b0};
                        end else begin
                            r_cs   <= C_CS0 << r_dchip;
                            r_di   <= 1'b1;
                            r_data <= bus.pixels;
                        end
                    end
                end

                default: r_state <= INIT;
            endcase
        end
    end

    assign bus.x          = r_x;
    assign bus.y          = r_y;
    assign bus.busy       = r_busy;
    assign bus.frame_done = r_done;
    assign bus.data_pin   = r_data;
    assign bus.cs_pin     = r_cs;
    assign bus.rw_pin     = 1'b0;
    assign bus.di_pin     = r_di;
    assign bus.enable_pin = r_en;
    assign bus.reset_pin  = r_rst_n;
endmodule
`default_nettype wire

// File: tb/tb_lcd_panel_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_panel_driver
// Brief    : Self-checking bench: bus-cycle capture compared against a table of
//            expected {di, data, cs} records, plus handshake/reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lcd_panel_driver;
    localparam int MPR = 2, MR = 2, XPM = 3, PG = 2;

    typedef struct packed {
        logic       di;
        logic [7:0] data;
        logic [3:0] cs;
    } bc_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    lcd_panel_driver_if #(.N(4), .XW(3), .YW(2)) bus ();

    lcd_panel_driver #(
        .MODULES_PER_ROW(MPR), .MODULE_ROWS(MR), .X_PER_MODULE(XPM),
        .PAGES_PER_MODULE(PG), .T_SETUP(2), .T_PULSE(2), .T_HOLD(2),
        .RESET_HOLD(4), .FB_LAT(1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Framebuffer model with one clock of read latency: pixel = {y,x}.
    always @(posedge clk) bus.pixels <= {3'b000, bus.y, bus.x};

    bc_t  bcq[$];
    int   fd_cnt = 0, bl_cnt = 0, cyc = 0, rp_rise_cyc = 0, cs_rise_cyc = 0;
    logic prev_en = 1'b1, prev_rp = 1'b0;
    logic [3:0] prev_cs = 4'b0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (prev_en && !bus.enable_pin)
            bcq.push_back('{bus.di_pin, bus.data_pin, bus.cs_pin});
        if (!prev_rp && bus.reset_pin) rp_rise_cyc = cyc;
        if (prev_cs == 4'b0 && bus.cs_pin != 4'b0) cs_rise_cyc = cyc;
        if (bus.frame_done) fd_cnt = fd_cnt + 1;
        if (!bus.busy) bl_cnt = bl_cnt + 1;
        prev_en = bus.enable_pin;
        prev_rp = bus.reset_pin;
        prev_cs = bus.cs_pin;
    end

    int  checks = 0, errors = 0;
    bc_t exp_tab[44];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_refresh();
        bus.refresh = 1'b1;
        tick();
        bus.refresh = 1'b0;
    endtask

    task automatic wait_fd(input int target, input int bound, input string name);
        int n = 0;
        while (fd_cnt < target && n < bound) begin
            tick();
            n++;
        end
        check(name, fd_cnt, target);
    endtask

    task automatic wait_idle(input int bound, input string name);
        int n = 0;
        while (bus.busy !== 1'b0 && n < bound) begin
            tick();
            n++;
        end
        check(name, {31'b0, bus.busy}, 0);
    endtask

    task automatic check_seq(input string name, input int qb, input int tb_i, input int n);
        for (int i = 0; i < n; i++) begin
            logic [31:0] got;
            got = (qb + i < bcq.size()) ? 32'(bcq[qb + i]) : 32'hFFFF_FFFF;
            check($sformatf("%s[%0d]", name, i), got, 32'(exp_tab[tb_i + i]));
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_data"},  {24'b0, bus.data_pin}, 0);
        check({tag, "_cs"},    {28'b0, bus.cs_pin}, 0);
        check({tag, "_rw"},    {31'b0, bus.rw_pin}, 0);
        check({tag, "_di"},    {31'b0, bus.di_pin}, 0);
        check({tag, "_en"},    {31'b0, bus.enable_pin}, 1);
        check({tag, "_rstn"},  {31'b0, bus.reset_pin}, 0);
        check({tag, "_x"},     {29'b0, bus.x}, 0);
        check({tag, "_y"},     {30'b0, bus.y}, 0);
        check({tag, "_busy"},  {31'b0, bus.busy}, 1);
        check({tag, "_done"},  {31'b0, bus.frame_done}, 0);
    endtask

    initial begin
        logic [7:0] cmds [3];
        int n, q0, f0, bl0, k;

        // Expected bus-cycle table: 12 init commands, then one full frame.
        cmds = '{8'h39, 8'h3B, 8'h3E};
        n = 0;
        for (int c = 0; c < 3; c++)
            for (int i = 0; i < 4; i++)
                exp_tab[n++] = '{1'b0, cmds[c], 4'b0001 << i};
        for (int p = 0; p < PG; p++) begin
            for (int i = 0; i < 4; i++)
                exp_tab[n++] = '{1'b0, {2'(p), 6'b0}, 4'b0001 << i};
            for (int r = 0; r < MR; r++)
                for (int c = 0; c < MPR * XPM; c++)
                    exp_tab[n++] = '{1'b1, {3'b000, 2'(r * PG + p), 3'(c)},
                                     4'b0001 << (r * MPR + c / XPM)};
        end

        bus.refresh = 1'b0;
        bus.auto_refresh = 1'b0;
        repeat (5) tick();
        check_reset_vals("rst");

        // Init sequence
        q0 = bcq.size();
        reset = 1'b0;
        tick();
        check("rstn_rise", {31'b0, bus.reset_pin}, 1);
        wait_idle(500, "init_idle");
        check("init_count", bcq.size() - q0, 12);
        check_seq("init_bc", q0, 0, 12);
        check("hold_clocks", cs_rise_cyc - rp_rise_cyc, 4);
        repeat (40) tick();
        check("init_no_extra", bcq.size() - q0, 12);
        check("idle_cs", {28'b0, bus.cs_pin}, 0);

        // Single frame with pixel-timing check
        q0 = bcq.size();
        f0 = fd_cnt;
        pulse_refresh();
        wait_fd(f0 + 1, 1000, "frame1_done");
        repeat (20) tick();
        check("frame1_count", bcq.size() - q0, 32);
        check_seq("frame1_bc", q0, 12, 32);
        check("frame1_fd", fd_cnt - f0, 1);
        check("frame1_idle", {31'b0, bus.busy}, 0);
        check("frame1_xy", {27'b0, bus.y, bus.x}, 0);

        // Three mid-frame requests collapse into one back-to-back frame
        q0 = bcq.size();
        f0 = fd_cnt;
        pulse_refresh();
        repeat (3) tick();
        bl0 = bl_cnt;
        repeat (20) tick();
        pulse_refresh();
        repeat (5) tick();
        pulse_refresh();
        repeat (5) tick();
        pulse_refresh();
        wait_fd(f0 + 1, 1000, "pend_fd1");
        wait_fd(f0 + 2, 1000, "pend_fd2");
        check("pend_busy_low", bl_cnt - bl0, 2);
        repeat (250) tick();
        check("pend_fd_total", fd_cnt - f0, 2);
        check("pend_count", bcq.size() - q0, 64);
        for (int f = 0; f < 2; f++) check_seq("pend_bc", q0 + 32 * f, 12, 32);

        // auto_refresh held for 2.5 frames
        q0 = bcq.size();
        f0 = fd_cnt;
        bus.auto_refresh = 1'b1;
        wait_fd(f0 + 2, 1000, "auto_fd2");
        repeat (96) tick();
        bus.auto_refresh = 1'b0;
        wait_fd(f0 + 3, 1000, "auto_fd3");
        repeat (250) tick();
        check("auto_fd_total", fd_cnt - f0, 3);
        check("auto_count", bcq.size() - q0, 96);
        check("auto_idle", {31'b0, bus.busy}, 0);
        for (int f = 0; f < 3; f++) check_seq("auto_bc", q0 + 32 * f, 12, 32);

        // Reset in the middle of the data BC at x=4, y=2
        pulse_refresh();
        k = 0;
        while (!(bus.x == 3'd4 && bus.y == 2'd2) && k < 1000) begin
            tick();
            k++;
        end
        check("abort_addr_seen", {27'b0, bus.y, bus.x}, {27'b0, 2'd2, 3'd4});
        repeat (3) tick();
        reset = 1'b1;
        tick();
        check_reset_vals("abort");
        repeat (3) tick();
        q0 = bcq.size();
        f0 = fd_cnt;
        reset = 1'b0;
        wait_idle(500, "reinit_idle");
        check("reinit_count", bcq.size() - q0, 12);
        check_seq("reinit_bc", q0, 0, 12);
        repeat (60) tick();
        check("reinit_no_frame", bcq.size() - q0, 12);
        check("reinit_no_fd", fd_cnt - f0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/lcd_panel_driver.md
Name: lcd_panel_driver

Overview:
Parametrised driver for tiled column-driver LCD panels built from MODULE_ROWS x MODULES_PER_ROW chips. Each chip is X_PER_MODULE columns wide and PAGES_PER_MODULE 8-pixel pages tall. The block runs the power-up/init command sequence, then streams framebuffer bytes to the panel, either one frame per refresh request or continuously. It sits between the framebuffer RAM (x/y address out, pixels in) and the LCD pins, and adds programmable bus timing, a request/busy/done handshake and pending-request queuing.

Parameters:
MODULES_PER_ROW, 5, chips per module row
MODULE_ROWS, 2, rows of chips
X_PER_MODULE, 50, columns per chip
PAGES_PER_MODULE, 4, 8-pixel pages per chip; the address command field is 2 bits, so max 4
T_SETUP, 8, clocks enable_pin stays high with cs/di/data stable before the falling edge
T_PULSE, 8, clocks enable_pin stays low
T_HOLD, 8, clocks enable_pin stays high after the rising edge before the next bus cycle
RESET_HOLD, 65536, clocks reset_pin stays low-released wait before the first command
FB_LAT, 1, framebuffer read latency in clocks

Derived constants:
N = MODULES_PER_ROW*MODULE_ROWS
W = MODULES_PER_ROW*X_PER_MODULE
XW = clog2(W)
YW = clog2(MODULE_ROWS*PAGES_PER_MODULE)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
refresh  in  1  one-clock request to draw one frame
auto_refresh  in  1  level; 1 = redraw frames back-to-back
pixels  in  8  framebuffer byte for (x,y), valid FB_LAT clocks after x/y change
x  out  XW  framebuffer column 0..W-1
y  out  YW  framebuffer page = row*PAGES_PER_MODULE + page
busy  out  1  high during init and during a frame
frame_done  out  1  one-clock pulse after the last data bus cycle of a frame
data_pin  out  8  LCD data bus
cs_pin  out  N  one-hot chip select
rw_pin  out  1  constant 0 (write only)
di_pin  out  1  0 = command, 1 = data
enable_pin  out  1  strobe; the LCD latches on the falling edge
reset_pin  out  1  LCD reset, active low

Behaviour:
- Reset: the interface is reset reset, synchronous, active-high; clock clk. While reset is high: data_pin=0, cs_pin=0, rw_pin=0, di_pin=0, enable_pin=1, reset_pin=0, x=0, y=0, busy=1, frame_done=0, pending=0, state=INIT.
- Reset asserted mid-operation: abort immediately, go to the reset values above, and rerun the whole init sequence.
- Bus cycle (BC):
  - cs/di/data_pin change only in the clock that starts a BC.
  - enable_pin then follows: T_SETUP clocks high, T_PULSE clocks low, T_HOLD clocks high.
  - Total BC length is T_SETUP+T_PULSE+T_HOLD clocks.
  - Exactly one falling edge per BC.
  - cs_pin returns to 0 only in IDLE; it is held between BCs.
- States:
  - INIT: raise reset_pin=1, count RESET_HOLD clocks, go to CMD.
  - CMD: broadcast three commands in order: 0x39 (display on), 0x3B (up mode), 0x3E (start page 0). Each command is sent as N BCs with di=0 and cs_pin=1<<i for i=0..N-1, giving 3N BCs in total. Then go to IDLE.
  - IDLE: busy=0. Start a frame if refresh, pending or auto_refresh is set; clear pending on start.
  - FRAME: for page p=0..PAGES_PER_MODULE-1:
    - ADDR: N BCs, di=0, data={p[1:0],6'b0}, cs stepping over chips 0..N-1.
    - Then for row r=0..MODULE_ROWS-1 and column c=0..W-1: y=r*PAGES_PER_MODULE+p, x=c.
    - Data BC: di=1, cs_pin one-hot for chip r*MODULES_PER_ROW + c/X_PER_MODULE, data_pin=pixels.
  - Address/data timing in FRAME:
    - x/y are updated FB_LAT+1 clocks before the BC start.
    - pixels are sampled into data_pin at the BC start.
    - The prefetch for the next BC overlaps the T_HOLD of the current one; T_HOLD >= FB_LAT+1 is required.
  - After the final data BC (p, r and c all at their maximum), pulse frame_done for one clock and go to IDLE.
    - x and y wrap to 0.
    - If pending or auto_refresh is set, start the next frame on the next clock with no IDLE gap beyond that one clock.
- Handshake:
  - refresh while busy sets pending.
  - Multiple requests collapse into one pending frame.
  - refresh in the same clock that frame_done pulses also sets pending.
  - refresh is ignored while reset is high.
- auto_refresh dropping mid-frame: the current frame completes and no further frame starts.
- Width rules:
  - x counts 0..W-1.
  - The column within a chip counts 0..X_PER_MODULE-1 and wraps to 0 while cs advances one position.
  - No counter may overflow; all compares are against constant maxima.

Test Plan:
All scenarios use small parameters: MODULES_PER_ROW=2, MODULE_ROWS=2, X_PER_MODULE=3, PAGES=2, T_*=2, RESET_HOLD=4, FB_LAT=1.
1. Deassert reset; no refresh -> reset_pin rises; 4 clocks later 12 enable falling edges occur with di=0. The data sequence is 0x39 x4, 0x3B x4, 0x3E x4, with cs cycling 0001, 0010, 0100, 1000. busy falls after the last BC, and there are no further edges.
2. One refresh pulse in IDLE -> 32 falling edges. The sequence is 4x cmd 0x00, then 12 data BCs (y=0,0,..,2), then 4x cmd 0x40, then 12 data BCs (y=1,..,3). The cs pattern is 0001 x3, 0010 x3 for y=0 and 0100 x3, 1000 x3 for y=2. frame_done pulses once.
3. Framebuffer model pixels = {y,x} -> every data BC latches data_pin equal to {y,x} of its own address; no off-by-one in sample timing.
4. refresh pulsed 3 times mid-frame -> exactly one extra frame follows immediately after frame_done; busy stays high across the boundary except for the 1 IDLE clock.
5. auto_refresh=1 for 2.5 frames, then 0 -> exactly 3 complete frames and 3 frame_done pulses, then IDLE.
6. reset asserted during the data BC at x=4, y=2 -> on the next clock all outputs equal their reset values; after release, the 12-BC init sequence repeats exactly.
